// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
//   Shared definitions for the Booth multiplier datapath and its consumers:
//   default widths, the accumulator FSM state type and a sign-extension helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package booth_pkg;

    localparam int PROD_W_DEF = 64;   // multiplier product width
    localparam int ACC_W_DEF  = 72;   // frame accumulator width (> PROD_W)
    localparam int CNT_W_DEF  = 10;   // frame length counter width

    // Widest value sign_extend() can produce; callers cast down to their width.
    localparam int EXT_MAX_W  = 128;
    localparam int EXT_IDX_W  = $clog2(EXT_MAX_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    // Replicates bit [width-1] of value into every higher bit position.
    // width must be a constant at the call site so this folds to wiring.
    function automatic logic [EXT_MAX_W-1:0] sign_extend(
        input logic [EXT_MAX_W-1:0] value,
        input int                   width
    );
        logic [EXT_MAX_W-1:0] result;
        logic [EXT_IDX_W-1:0] msb;
        msb    = EXT_IDX_W'(width - 1);
        result = value;
        for (int i = 0; i < EXT_MAX_W; i++) begin
            if (i >= width) begin
                result[i] = value[msb];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/acc_signed_adder.sv
// -----------------------------------------------------------------------------
// acc_signed_adder
//   Combinational two's-complement adder with signed-overflow detection.
//   The sum wraps modulo 2^W; ovf flags that the wrapped result no longer
//   equals the true sum (operands share a sign that the result does not).
//
//   Ports:
//     a, b  in   W  signed operands
//     sum   out  W  a + b, wrapped
//     ovf   out  1  signed overflow of this addition
// -----------------------------------------------------------------------------
module acc_signed_adder
    import booth_pkg::*;
#(
    parameter int W = ACC_W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    assign sum = a + b;
    assign ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);

endmodule

// File: rtl/booth_product_accumulator.sv
// -----------------------------------------------------------------------------
// booth_product_accumulator
//   Sums a frame of `len` signed products (one per cycle over a valid/ready
//   handshake) into a wide signed accumulator and presents the frame sum,
//   a sticky overflow flag, a fits-in-PROD_W flag and the product count over
//   a second valid/ready handshake.
//
//   Ports:
//     clk         in   1       rising-edge clock
//     reset       in   1       synchronous active-high reset
//     clear       in   1       synchronous frame abort (back to IDLE)
//     len         in   CNT_W   frame length, sampled on a frame's first product
//                              (0 behaves as 1)
//     prod_valid  in   1       prod_data valid
//     prod_ready  out  1       a product can be accepted this cycle
//     prod_data   in   PROD_W  signed product
//     acc_valid   out  1       frame result available
//     acc_ready   in   1       downstream accepts the result
//     acc_data    out  ACC_W   signed frame sum (wraps modulo 2^ACC_W)
//     acc_ovf     out  1       sticky signed overflow during the frame
//     acc_fits64  out  1       acc_data representable in PROD_W signed bits
//     acc_count   out  CNT_W   number of products summed
// -----------------------------------------------------------------------------
module booth_product_accumulator
    import booth_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,    // must exceed PROD_W
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [CNT_W-1:0]  len,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod_data,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc_data,
    output logic              acc_ovf,
    output logic              acc_fits64,
    output logic [CNT_W-1:0]  acc_count
);

    acc_state_t        state;
    acc_state_t        state_next;

    logic [ACC_W-1:0]  acc_q;
    logic              ovf_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  remaining_q;    // products still owed after this one

    logic              prod_xfer;
    logic              acc_xfer;
    logic [CNT_W-1:0]  first_remaining;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  sum;
    logic              sum_ovf;

    // Handshake-visible state: accept products until the frame completes,
    // then hold the result until it is taken.
    assign prod_ready = (state != DONE);
    assign acc_valid  = (state == DONE);

    assign prod_xfer  = prod_valid && prod_ready;
    assign acc_xfer   = acc_valid && acc_ready;

    // len == 0 is treated as a one-product frame.
    assign first_remaining = (len == '0) ? '0 : len - CNT_W'(1);

    assign prod_ext = ACC_W'(sign_extend(EXT_MAX_W'(prod_data), PROD_W));

    acc_signed_adder #(
        .W   (ACC_W)
    ) u_adder (
        .a   (acc_q),
        .b   (prod_ext),
        .sum (sum),
        .ovf (sum_ovf)
    );

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (prod_xfer) begin
                    state_next = (first_remaining == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (prod_xfer && (remaining_q == CNT_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (acc_xfer) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Abort wins over any transfer seen in the same cycle.
        if (clear) begin
            state_next = IDLE;
        end
    end

    // Result registers hold through DONE and IDLE; only a product transfer
    // (or reset/clear) changes them.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
            remaining_q <= '0;
        end else if (prod_xfer) begin
            if (state == IDLE) begin
                acc_q       <= prod_ext;
                ovf_q       <= 1'b0;
                count_q     <= CNT_W'(1);
                remaining_q <= first_remaining;
            end else begin
                acc_q       <= sum;
                ovf_q       <= ovf_q | sum_ovf;
                count_q     <= count_q + CNT_W'(1);
                remaining_q <= remaining_q - CNT_W'(1);
            end
        end
    end

    assign acc_data  = acc_q;
    assign acc_ovf   = ovf_q;
    assign acc_count = count_q;

    // Fits in PROD_W signed iff every bit from the PROD_W sign bit upward agrees.
    assign acc_fits64 = (acc_q[ACC_W-1:PROD_W-1] == '0) || (&acc_q[ACC_W-1:PROD_W-1]);

endmodule

// File: tb/tb_booth_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_booth_product_accumulator
//   Scoreboard bench: stimulus computes each frame's expected result with plain
//   wide-integer arithmetic and queues it; a monitor pops and compares on every
//   result transfer. Directed sequences cover latency, back-pressure, clear,
//   len = 0 and reset; a randomized phase adds bubbles and acc_ready toggling.
// -----------------------------------------------------------------------------
module tb_booth_product_accumulator;

    localparam int PROD_W = 64;
    localparam int ACC_W  = 72;
    localparam int CNT_W  = 10;

    localparam logic signed [127:0] ACC_MAX  = (128'sd1 <<< 71) - 128'sd1;
    localparam logic signed [127:0] ACC_MIN  = -(128'sd1 <<< 71);
    localparam logic signed [127:0] ACC_SPAN = 128'sd1 <<< 72;
    localparam logic signed [127:0] P_MAX    = (128'sd1 <<< 63) - 128'sd1;
    localparam logic signed [127:0] P_MIN    = -(128'sd1 <<< 63);

    localparam longint TWO_62 = 64'sd4611686018427387904;

    typedef struct {
        logic [ACC_W-1:0] data;
        logic             ovf;
        logic             fits;
        logic [CNT_W-1:0] count;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear;
    logic [CNT_W-1:0]  len;
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] prod_data;
    logic              acc_valid;
    logic              acc_ready;
    logic [ACC_W-1:0]  acc_data;
    logic              acc_ovf;
    logic              acc_fits64;
    logic [CNT_W-1:0]  acc_count;

    int     n_checks = 0;
    int     n_errors = 0;
    exp_t   exp_q[$];
    longint stim_q[$];
    bit     rand_ready = 1'b0;
    exp_t   mon_e;

    booth_product_accumulator #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .len        (len),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod_data  (prod_data),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc_data   (acc_data),
        .acc_ovf    (acc_ovf),
        .acc_fits64 (acc_fits64),
        .acc_count  (acc_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact running sum, wrapped back into the ACC_W signed range
    // whenever it leaves it; leaving the range is what overflow means.
    function automatic exp_t model(input longint prods[$]);
        exp_t r;
        logic signed [127:0] run;
        logic signed [127:0] exact;
        run   = 128'sd0;
        r.ovf = 1'b0;
        foreach (prods[i]) begin
            exact = run + prods[i];
            run   = exact;
            if (exact > ACC_MAX) begin
                r.ovf = 1'b1;
                run   = exact - ACC_SPAN;
            end else if (exact < ACC_MIN) begin
                r.ovf = 1'b1;
                run   = exact + ACC_SPAN;
            end
        end
        r.data  = run[ACC_W-1:0];
        r.fits  = (run >= P_MIN) && (run <= P_MAX);
        r.count = CNT_W'(prods.size());
        return r;
    endfunction

    // Monitor: every result transfer is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && acc_valid && acc_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 128'(acc_valid), 128'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("acc_data",   128'(acc_data),   128'(mon_e.data));
                check("acc_ovf",    128'(acc_ovf),    128'(mon_e.ovf));
                check("acc_fits64", 128'(acc_fits64), 128'(mon_e.fits));
                check("acc_count",  128'(acc_count),  128'(mon_e.count));
            end
        end
    end

    // Random back-pressure during the randomized phase.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1 acc_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Call from the post-posedge phase; returns just after the accepting edge.
    task automatic push_product(input longint p);
        int waited;
        waited     = 0;
        prod_valid = 1'b1;
        prod_data  = p;
        @(negedge clk);
        while (!prod_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!prod_ready) begin
            check("prod_ready_wait", 128'(prod_ready), 128'(1));
        end
        sync();
    endtask

    task automatic run_frame(input logic [CNT_W-1:0] flen, input int gap,
                             input bit track, output exp_t e);
        int g;
        e = model(stim_q);
        if (track) begin
            exp_q.push_back(e);
        end
        sync();
        len = flen;
        foreach (stim_q[i]) begin
            if (i > 0) begin
                g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                prod_valid = 1'b0;
                repeat (g) sync();
            end
            push_product(stim_q[i]);
            // Mid-frame len changes must be ignored.
            len = CNT_W'($urandom);
        end
        prod_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int waited;
        waited = 0;
        @(negedge clk);
        while (!acc_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!acc_valid) begin
            check("acc_valid_wait", 128'(acc_valid), 128'(1));
        end
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            check("scoreboard_drain", 128'(exp_q.size()), 128'(0));
            exp_q.delete();
        end
    endtask

    function automatic longint rand_product();
        case ($urandom_range(0, 3))
            0:       return 64'sh7fff_ffff_ffff_ffff;
            1:       return 64'sh8000_0000_0000_0000;
            default: return longint'({$urandom, $urandom});
        endcase
    endfunction

    initial begin
        exp_t e;
        int   n;
        logic [CNT_W-1:0] flen;

        reset      = 1'b1;
        clear      = 1'b0;
        len        = '0;
        prod_valid = 1'b0;
        prod_data  = '0;
        acc_ready  = 1'b1;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_acc_valid",  128'(acc_valid),  128'(0));
        check("rst_prod_ready", 128'(prod_ready), 128'(1));
        check("rst_acc_data",   128'(acc_data),   128'(0));
        check("rst_acc_ovf",    128'(acc_ovf),    128'(0));
        check("rst_acc_count",  128'(acc_count),  128'(0));
        check("rst_acc_fits64", 128'(acc_fits64), 128'(1));

        // 1: single-product frame, latency and return to IDLE.
        stim_q = '{64'sd3154025};
        run_frame(10'd1, 0, 1'b1, e);
        @(negedge clk);
        check("t1_valid_next_cycle", 128'(acc_valid),  128'(1));
        check("t1_ready_low_done",   128'(prod_ready), 128'(0));
        sync();
        @(negedge clk);
        check("t1_idle_prod_ready",  128'(prod_ready), 128'(1));
        check("t1_idle_acc_valid",   128'(acc_valid),  128'(0));
        check("t1_idle_holds_data",  128'(acc_data),   128'(e.data));
        wait_drain();

        // 2: three products gapped by two idle cycles.
        stim_q = '{-64'sd4611686016279904256, TWO_62, 64'sd0};
        run_frame(10'd3, 2, 1'b1, e);
        check("t2_model_sum", 128'(e.data), 128'(72'd2147483648));
        wait_drain();

        // 3: sum leaves 64-bit range; result held under back-pressure.
        acc_ready = 1'b0;
        stim_q = '{TWO_62, TWO_62, TWO_62, TWO_62};
        run_frame(10'd4, 0, 1'b1, e);
        wait_valid();
        repeat (5) begin
            @(negedge clk);
            check("t3_hold_valid",  128'(acc_valid),  128'(1));
            check("t3_hold_pready", 128'(prod_ready), 128'(0));
            check("t3_hold_data",   128'(acc_data),   128'(e.data));
            check("t3_hold_fits",   128'(acc_fits64), 128'(e.fits));
            check("t3_hold_count",  128'(acc_count),  128'(e.count));
        end
        sync();
        acc_ready = 1'b1;
        wait_drain();

        // 4: 512 x 2^62 wraps to -2^71 with sticky overflow.
        stim_q.delete();
        repeat (512) stim_q.push_back(TWO_62);
        run_frame(10'd512, 0, 1'b1, e);
        check("t4_model_ovf", 128'(e.ovf), 128'(1));
        wait_drain();

        // 5: clear coincident with the third product of a len=4 frame.
        sync();
        len = 10'd4;
        push_product(64'sd11);
        push_product(64'sd22);
        prod_data = 64'sd33;
        clear     = 1'b1;
        sync();
        clear      = 1'b0;
        prod_valid = 1'b0;
        @(negedge clk);
        check("t5_clr_prod_ready", 128'(prod_ready), 128'(1));
        check("t5_clr_acc_valid",  128'(acc_valid),  128'(0));
        check("t5_clr_acc_data",   128'(acc_data),   128'(0));
        check("t5_clr_acc_count",  128'(acc_count),  128'(0));
        check("t5_clr_acc_ovf",    128'(acc_ovf),    128'(0));
        stim_q = '{64'sd5};
        run_frame(10'd1, 0, 1'b1, e);
        wait_drain();

        // Randomized frames with bubbles, mid-frame len changes, random acc_ready.
        rand_ready = 1'b1;
        for (int f = 0; f < 30; f++) begin
            flen = CNT_W'($urandom_range(0, 8));
            n    = (flen == '0) ? 1 : int'(flen);
            stim_q.delete();
            for (int k = 0; k < n; k++) stim_q.push_back(rand_product());
            run_frame(flen, -1, 1'b1, e);
        end
        sync();
        rand_ready = 1'b0;
        sync();
        acc_ready = 1'b1;
        wait_drain();

        // 6: len=0 behaves as one product; reset while in DONE.
        acc_ready = 1'b0;
        stim_q = '{-64'sd2031232132};
        run_frame(10'd0, 0, 1'b0, e);
        wait_valid();
        check("t6_data",  128'(acc_data),   128'(e.data));
        check("t6_count", 128'(acc_count),  128'(e.count));
        check("t6_fits",  128'(acc_fits64), 128'(e.fits));
        sync();
        reset = 1'b1;
        sync();
        reset = 1'b0;
        @(negedge clk);
        check("t6_rst_acc_valid",  128'(acc_valid),  128'(0));
        check("t6_rst_prod_ready", 128'(prod_ready), 128'(1));
        check("t6_rst_acc_data",   128'(acc_data),   128'(0));
        acc_ready = 1'b1;

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
